lmsm_decode_stage: RTL and testbench
====================================

# lmsm_decode_stage

Registered instruction-decode stage for the IITB-RISC pipeline. It sits between the IF/ID register and register read, and turns each instruction word into a registered control bundle behind a valid/ready handshake. LM/SM instructions are expanded into one micro-op per register in the list, and upstream is stalled while the expansion runs. Pipeline flush and HALT are supported.

## Interface
- `IW_W`, 16: instruction word width; opcode is `iw[IW_W-1:IW_W-4]`.
- `PC_W`, 16: PC width.
- `NREG`, 8: LM/SM register-list width, taken from `iw[NREG-1:0]`; legal range 2..9.
- `RIDX_W`, $clog2(NREG): width of the register index and offset.

- `clk`, input, 1: clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `in_valid`, input, 1: an instruction is offered.
- `in_ready`, output, 1: the stage accepts the instruction this cycle.
- `iw`, input, IW_W: instruction word.
- `in_pc`, input, PC_W: PC of `iw`.
- `flush`, input, 1: kill the held and in-expansion work.
- `out_valid`, output, 1: the control bundle is valid.
- `out_ready`, input, 1: downstream consumes the bundle.
- `out_iw` / `out_pc`, output, IW_W / PC_W: the held instruction word and its PC.
- `r_type`, `w_reg`, `w_mem`, `sel69`, `lhi`, `lw_sr`, `mem_ans`, `stop`, output, 1 each: decoded controls.
- `rd_sel`, output, 2: destination select (00 RA, 01 RB, 10 RC, 11 LM/SM list).
- `alu_op`, output, 3: ALU operation.
- `lmstart`, output, 2: LM/SM mode.
- `jump`, output, 2: jump type.
- `out_reg_idx`, output, RIDX_W: register for the LM/SM micro-op.
- `out_offset`, output, RIDX_W: memory word offset of the micro-op.
- `out_first` / `out_last`, output, 1 each: first / last micro-op of the instruction.
- `halted`, output, 1: the stage is halted.

## Operation
Decoded controls default to all zero (NOP). Only the non-zero fields are listed per opcode.
- `0000` ADD/ADZ/ADC, selected by `iw[1:0]` = 00/01/10: `rd_sel`=10, `w_reg`, `mem_ans`, `alu_op` = 001/011/010.
- `0010` NDU/NDZ/NDC, selected by `iw[1:0]` = 00/01/10: `rd_sel`=10, `w_reg`, `mem_ans`, `alu_op` = 100/110/101.
- `iw[1:0]`=11 on opcode 0000 or 0010: NOP.
- `0001` ADI: `r_type`, `rd_sel`=01, `w_reg`, `alu_op`=001, `mem_ans`.
- `0100` LW: `r_type`, `w_reg`, `lw_sr`.
- `0101` SW: `r_type`, `w_mem`, `lw_sr`.
- `1100` BEQ: `alu_op`=111, `mem_ans`, `jump`=01.
- `1000` JAL: `r_type`, `w_reg`, `sel69`, `alu_op`=111, `mem_ans`, `jump`=10.
- `1001` JLR: `w_reg`, `alu_op`=111, `mem_ans`, `jump`=11.
- `0011` LHI: `r_type`, `w_reg`, `sel69`, `lhi`, `alu_op`=111, `mem_ans`.
- `0110` LM: `rd_sel`=11, `w_reg`, `lhi`, `alu_op`=111, `lmstart`=11.
- `0111` SM: `rd_sel`=11, `w_mem`, `lhi`, `alu_op`=111, `lmstart`=10.
- `iw` all ones: HALT, with `lhi`, `alu_op`=111, `mem_ans`, `stop`. HALT is checked before the opcode cases. `stop` is 1 only on HALT.
- Any other encoding: NOP.

State machine with states IDLE, EXPAND and HALTED:
- `in_ready` = (state==IDLE) & (!`out_valid` | `out_ready`) & !`flush`.
- A non-LM/SM instruction emits one bundle with `out_first`=`out_last`=1, `out_reg_idx`=0 and `out_offset`=0.
- LM/SM with a non-zero list: the accept emits the micro-op for the lowest set bit, with `out_first`=1 and `out_offset`=0. The remaining bits are latched in a mask and the state moves to EXPAND.
- In EXPAND, each time the output slot frees, the next-lowest set bit is loaded and `out_offset` increments by 1.
- `out_last`=1 on the micro-op for the highest set bit. The state returns to IDLE when that micro-op is loaded.
- LM/SM with an empty list: a single bundle is emitted with `w_reg`=`w_mem`=0 and `out_first`=`out_last`=1.

## Timing
- Reset: state IDLE, `out_valid`=0, mask=0, `halted`=0, and every data and control output is 0.
- Latency: accept in cycle t gives `out_valid`=1 in cycle t+1.
- The output register holds its contents while `out_valid` & !`out_ready`.
- An LM/SM with k set bits holds `in_ready`=0 for k-1 cycles when there is no downstream stall.
- `flush`:
  - On the next edge, `out_valid`=0, the mask is cleared and the state returns to IDLE.
  - `flush` has priority over an accept or a load in the same cycle.
  - An unconsumed HALT is killed.
- Reset asserted mid-expansion: everything returns to reset values immediately.

## Configuration
- `LMSM_DEC_HALT_STICKY_EN` defined: when the HALT bundle transfers (`out_valid`&`out_ready`), the state moves to HALTED. In HALTED, `halted`=1 and `in_ready`=0; `flush` does not leave it, only `rst_n` does.
- Undefined: HALT is an ordinary single bundle, decode continues, and `halted` is tied to 0.

## Test plan
- ADC `iw`=16'h0A52 with `out_ready`=1 → next cycle: `rd_sel`=10, `alu_op`=010, `w_reg`=1, `mem_ans`=1, `out_first`=`out_last`=1.
- LM with list 8'b1010_0100 and `out_ready`=1 → three bundles with `out_reg_idx`=2/5/7, `out_offset`=0/1/2, `out_last` only on the third. `in_ready` is low for 2 cycles.
- SM with list 0x81 while `out_ready` is low for 3 cycles after the first micro-op → micro-op 0 held stable, then idx 7 with offset 1. `lmstart`=10 and `w_mem`=1 on both.
- `flush` during the 2nd LM micro-op, with a same-cycle `in_valid` → `out_valid`=0 next cycle, state IDLE, the offered instruction is not accepted, and it is accepted the following cycle.
- HALT 16'hFFFF consumed with `LMSM_DEC_HALT_STICKY_EN` defined → `stop`=1 for one bundle, then `halted`=1 and `in_ready`=0 persist through `flush`. After `rst_n` pulses low, `halted`=0.
- Opcode 0000 with `iw[1:0]`=11, and opcode 1111 not all ones → NOP bundle with all controls 0 and `out_valid`=1.

Source files
------------

// File: rtl/lmsm_decode_stage.sv
// -----------------------------------------------------------------------------
// lmsm_decode_stage
//
// Registered instruction-decode stage for the IITB-RISC pipeline. Each accepted
// instruction word is decoded into a control bundle held in an output register.
// LM/SM instructions are expanded into one micro-op per set bit of the register
// list (lowest bit first). Upstream is stalled while the expansion runs.
//
// Optional feature (compile-time macro LMSM_DEC_HALT_STICKY_EN):
//   defined   - once the HALT bundle transfers downstream the stage parks in
//               HALTED (halted=1, in_ready=0) until rst_n is asserted.
//   undefined - HALT is an ordinary single bundle and halted is tied to 0.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   in_valid/in_ready       upstream handshake, iw + in_pc payload
//   flush                   kill held output and any in-progress expansion
//   out_valid/out_ready     downstream handshake
//   out_iw, out_pc          held instruction word and its PC
//   r_type .. jump          decoded control fields
//   out_reg_idx, out_offset LM/SM micro-op register index and word offset
//   out_first, out_last     first / last micro-op of an instruction
//   halted                  stage is halted (sticky build only)
//   dbg_state               FSM state: 0 IDLE, 1 EXPAND, 2 HALTED
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A producer keeps valid and its payload stable until the transfer;
// ready never depends on valid on the same side.
// -----------------------------------------------------------------------------
module lmsm_decode_stage #(
  parameter int IW_W   = 16,
  parameter int PC_W   = 16,
  parameter int NREG   = 8,
  parameter int RIDX_W = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IW_W-1:0]   iw,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IW_W-1:0]   out_iw,
  output logic [PC_W-1:0]   out_pc,
  output logic              r_type,
  output logic              w_reg,
  output logic              w_mem,
  output logic              sel69,
  output logic              lhi,
  output logic              lw_sr,
  output logic              mem_ans,
  output logic              stop,
  output logic [1:0]        rd_sel,
  output logic [2:0]        alu_op,
  output logic [1:0]        lmstart,
  output logic [1:0]        jump,
  output logic [RIDX_W-1:0] out_reg_idx,
  output logic [RIDX_W-1:0] out_offset,
  output logic              out_first,
  output logic              out_last,
  output logic              halted,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic       r_type;
    logic       w_reg;
    logic       w_mem;
    logic       sel69;
    logic       lhi;
    logic       lw_sr;
    logic       mem_ans;
    logic       stop;
    logic [1:0] rd_sel;
    logic [2:0] alu_op;
    logic [1:0] lmstart;
    logic [1:0] jump;
  } ctrl_t;

  state_t            state, state_nx;
  ctrl_t             dec, ctrl_q;
  logic [NREG-1:0]   mask;
  logic [3:0]        opcode;
  logic [NREG-1:0]   in_list;
  logic              in_lmsm_go;
  logic [RIDX_W-1:0] in_idx, m_idx;
  logic [NREG-1:0]   in_rest, m_rest;
  logic              accept, load;

  // Index of the lowest set bit (0 when m is empty).
  function automatic logic [RIDX_W-1:0] low_idx(input logic [NREG-1:0] m);
    logic [RIDX_W-1:0] r;
    r = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (m[i]) r = RIDX_W'(i);
    end
    return r;
  endfunction

  // m with its lowest set bit cleared.
  function automatic logic [NREG-1:0] clr_low(input logic [NREG-1:0] m);
    return m & (m - NREG'(1));
  endfunction

  assign opcode  = iw[IW_W-1 -: 4];
  assign in_list = iw[NREG-1:0];

  // ---------------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------------
  always_comb begin
    dec = '0;
    if (iw == {IW_W{1'b1}}) begin
      // HALT takes precedence over the opcode table (opcode 1111 otherwise NOP)
      dec.lhi     = 1'b1;
      dec.alu_op  = 3'b111;
      dec.mem_ans = 1'b1;
      dec.stop    = 1'b1;
    end else begin
      case (opcode)
        4'b0000: begin
          if (iw[1:0] != 2'b11) begin
            dec.rd_sel  = 2'b10;
            dec.w_reg   = 1'b1;
            dec.mem_ans = 1'b1;
            case (iw[1:0])
              2'b00:   dec.alu_op = 3'b001;
              2'b01:   dec.alu_op = 3'b011;
              default: dec.alu_op = 3'b010;
            endcase
          end
        end
        4'b0010: begin
          if (iw[1:0] != 2'b11) begin
            dec.rd_sel  = 2'b10;
            dec.w_reg   = 1'b1;
            dec.mem_ans = 1'b1;
            case (iw[1:0])
              2'b00:   dec.alu_op = 3'b100;
              2'b01:   dec.alu_op = 3'b110;
              default: dec.alu_op = 3'b101;
            endcase
          end
        end
        4'b0001: begin
          dec.r_type  = 1'b1;
          dec.rd_sel  = 2'b01;
          dec.w_reg   = 1'b1;
          dec.alu_op  = 3'b001;
          dec.mem_ans = 1'b1;
        end
        4'b0100: begin
          dec.r_type = 1'b1;
          dec.w_reg  = 1'b1;
          dec.lw_sr  = 1'b1;
        end
        4'b0101: begin
          dec.r_type = 1'b1;
          dec.w_mem  = 1'b1;
          dec.lw_sr  = 1'b1;
        end
        4'b1100: begin
          dec.alu_op  = 3'b111;
          dec.mem_ans = 1'b1;
          dec.jump    = 2'b01;
        end
        4'b1000: begin
          dec.r_type  = 1'b1;
          dec.w_reg   = 1'b1;
          dec.sel69   = 1'b1;
          dec.alu_op  = 3'b111;
          dec.mem_ans = 1'b1;
          dec.jump    = 2'b10;
        end
        4'b1001: begin
          dec.w_reg   = 1'b1;
          dec.alu_op  = 3'b111;
          dec.mem_ans = 1'b1;
          dec.jump    = 2'b11;
        end
        4'b0011: begin
          dec.r_type  = 1'b1;
          dec.w_reg   = 1'b1;
          dec.sel69   = 1'b1;
          dec.lhi     = 1'b1;
          dec.alu_op  = 3'b111;
          dec.mem_ans = 1'b1;
        end
        4'b0110: begin
          // empty list: single bundle with no register write
          dec.rd_sel  = 2'b11;
          dec.w_reg   = |in_list;
          dec.lhi     = 1'b1;
          dec.alu_op  = 3'b111;
          dec.lmstart = 2'b11;
        end
        4'b0111: begin
          dec.rd_sel  = 2'b11;
          dec.w_mem   = |in_list;
          dec.lhi     = 1'b1;
          dec.alu_op  = 3'b111;
          dec.lmstart = 2'b10;
        end
        default: dec = '0;
      endcase
    end
  end

  // LM/SM micro-op selection: for the incoming word and for the pending mask
  assign in_lmsm_go = ((opcode == 4'b0110) || (opcode == 4'b0111)) && (|in_list);
  assign in_idx     = in_lmsm_go ? low_idx(in_list) : '0;
  assign in_rest    = in_lmsm_go ? clr_low(in_list) : '0;
  assign m_idx      = low_idx(mask);
  assign m_rest     = clr_low(mask);

  assign accept = in_valid && in_ready;
  // next micro-op enters whenever the output slot is free or being drained
  assign load   = (state == S_EXPAND) && (!out_valid || out_ready) && !flush;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept && (in_rest != '0)) state_nx = S_EXPAND;
      end
      S_EXPAND: begin
        if (flush)                        state_nx = S_IDLE;
        else if (load && (m_rest == '0))  state_nx = S_IDLE;
      end
      S_HALTED: state_nx = S_HALTED;
      default:  state_nx = S_IDLE;
    endcase
`ifdef LMSM_DEC_HALT_STICKY_EN
    if ((state != S_HALTED) && out_valid && out_ready && ctrl_q.stop)
      state_nx = S_HALTED;
`endif
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state == S_IDLE) && (!out_valid || out_ready) && !flush;
    dbg_state = state;
`ifdef LMSM_DEC_HALT_STICKY_EN
    // nothing may follow a HALT into the output slot on its transfer edge
    if (out_valid && ctrl_q.stop) in_ready = 1'b0;
    halted = (state == S_HALTED);
`else
    halted = 1'b0;
`endif
  end

  // ---------------------------------------------------------------------------
  // Output register and pending LM/SM mask
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_iw      <= '0;
      out_pc      <= '0;
      ctrl_q      <= '0;
      out_reg_idx <= '0;
      out_offset  <= '0;
      out_first   <= 1'b0;
      out_last    <= 1'b0;
      mask        <= '0;
    end else if (flush) begin
      // payload is left as-is; only validity and pending work are killed
      out_valid <= 1'b0;
      mask      <= '0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_iw      <= iw;
      out_pc      <= in_pc;
      ctrl_q      <= dec;
      out_reg_idx <= in_idx;
      out_offset  <= '0;
      out_first   <= 1'b1;
      out_last    <= (in_rest == '0);
      mask        <= in_rest;
    end else if (load) begin
      // instruction fields stay put; only the micro-op fields advance
      out_valid   <= 1'b1;
      out_reg_idx <= m_idx;
      out_offset  <= out_offset + RIDX_W'(1);
      out_first   <= 1'b0;
      out_last    <= (m_rest == '0);
      mask        <= m_rest;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign r_type  = ctrl_q.r_type;
  assign w_reg   = ctrl_q.w_reg;
  assign w_mem   = ctrl_q.w_mem;
  assign sel69   = ctrl_q.sel69;
  assign lhi     = ctrl_q.lhi;
  assign lw_sr   = ctrl_q.lw_sr;
  assign mem_ans = ctrl_q.mem_ans;
  assign stop    = ctrl_q.stop;
  assign rd_sel  = ctrl_q.rd_sel;
  assign alu_op  = ctrl_q.alu_op;
  assign lmstart = ctrl_q.lmstart;
  assign jump    = ctrl_q.jump;

endmodule

// File: tb/tb_lmsm_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_lmsm_decode_stage
//
// Directed bench for lmsm_decode_stage. Expected control bundles are written
// out by hand as 17-bit words in the order
//   {r_type,w_reg,w_mem,sel69,lhi,lw_sr,mem_ans,stop,rd_sel,alu_op,lmstart,jump}
// LM/SM micro-op sequences go through an expected queue of
//   {reg_idx[2:0], offset[2:0], first, last}.
// -----------------------------------------------------------------------------
module tb_lmsm_decode_stage;

  localparam int IW_W   = 16;
  localparam int PC_W   = 16;
  localparam int NREG   = 8;
  localparam int RIDX_W = 3;

  localparam logic [16:0] C_ADD  = 17'b0100_0010_10_001_00_00;
  localparam logic [16:0] C_ADC  = 17'b0100_0010_10_010_00_00;
  localparam logic [16:0] C_LM   = 17'b0100_1000_11_111_11_00;
  localparam logic [16:0] C_SM   = 17'b0010_1000_11_111_10_00;
  localparam logic [16:0] C_HALT = 17'b0000_1011_00_111_00_00;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready, flush;
  logic [IW_W-1:0]   iw;
  logic [PC_W-1:0]   in_pc;
  logic              out_valid, out_ready;
  logic [IW_W-1:0]   out_iw;
  logic [PC_W-1:0]   out_pc;
  logic              r_type, w_reg, w_mem, sel69, lhi, lw_sr, mem_ans, stop;
  logic [1:0]        rd_sel, lmstart, jump;
  logic [2:0]        alu_op;
  logic [RIDX_W-1:0] out_reg_idx, out_offset;
  logic              out_first, out_last, halted;
  logic [1:0]        dbg_state;
  logic [16:0]       ctl;
  logic [7:0]        uop;

  always #5 clk = ~clk;

  lmsm_decode_stage #(.IW_W(IW_W), .PC_W(PC_W), .NREG(NREG), .RIDX_W(RIDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .iw(iw), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_iw(out_iw), .out_pc(out_pc),
    .r_type(r_type), .w_reg(w_reg), .w_mem(w_mem), .sel69(sel69),
    .lhi(lhi), .lw_sr(lw_sr), .mem_ans(mem_ans), .stop(stop),
    .rd_sel(rd_sel), .alu_op(alu_op), .lmstart(lmstart), .jump(jump),
    .out_reg_idx(out_reg_idx), .out_offset(out_offset),
    .out_first(out_first), .out_last(out_last),
    .halted(halted), .dbg_state(dbg_state)
  );

  assign ctl = {r_type, w_reg, w_mem, sel69, lhi, lw_sr, mem_ans, stop,
                rd_sel, alu_op, lmstart, jump};
  assign uop = {out_reg_idx, out_offset, out_first, out_last};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Scoreboard / checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_uop_q(input string tag);
    if (exp_q.size() == 0) check({tag, "_q_empty"}, 32'd1, 32'd0);
    else                   check(tag, {24'd0, uop}, {24'd0, exp_q.pop_front()});
  endtask

  // driver: advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // directed decode vectors
  logic [15:0] vec_iw [18];
  logic [16:0] vec_ctl[18];

  initial begin
    vec_iw[0]  = 16'h0A50; vec_ctl[0]  = C_ADD;
    vec_iw[1]  = 16'h0A51; vec_ctl[1]  = 17'b0100_0010_10_011_00_00; // ADZ
    vec_iw[2]  = 16'h2A50; vec_ctl[2]  = 17'b0100_0010_10_100_00_00; // NDU
    vec_iw[3]  = 16'h2A52; vec_ctl[3]  = 17'b0100_0010_10_101_00_00; // NDC
    vec_iw[4]  = 16'h2051; vec_ctl[4]  = 17'b0100_0010_10_110_00_00; // NDZ
    vec_iw[5]  = 16'h1234; vec_ctl[5]  = 17'b1100_0010_01_001_00_00; // ADI
    vec_iw[6]  = 16'h4567; vec_ctl[6]  = 17'b1100_0100_00_000_00_00; // LW
    vec_iw[7]  = 16'h5ABC; vec_ctl[7]  = 17'b1010_0100_00_000_00_00; // SW
    vec_iw[8]  = 16'hC00F; vec_ctl[8]  = 17'b0000_0010_00_111_00_01; // BEQ
    vec_iw[9]  = 16'h8123; vec_ctl[9]  = 17'b1101_0010_00_111_00_10; // JAL
    vec_iw[10] = 16'h9040; vec_ctl[10] = 17'b0100_0010_00_111_00_11; // JLR
    vec_iw[11] = 16'h3FFF; vec_ctl[11] = 17'b1101_1010_00_111_00_00; // LHI
    vec_iw[12] = 16'h0003; vec_ctl[12] = 17'd0;                      // ADD xx=11
    vec_iw[13] = 16'hF000; vec_ctl[13] = 17'd0;                      // 1111 not HALT
    vec_iw[14] = 16'h2003; vec_ctl[14] = 17'd0;                      // NDU xx=11
    vec_iw[15] = 16'hA123; vec_ctl[15] = 17'd0;                      // unused opcode
    vec_iw[16] = 16'h6F00; vec_ctl[16] = 17'b0000_1000_11_111_11_00; // LM empty
    vec_iw[17] = 16'h7F00; vec_ctl[17] = 17'b0000_1000_11_111_10_00; // SM empty
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; iw = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_ctl", ctl, 0);
    check("rst_out_iw", out_iw, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_uop", uop, 0);
    check("rst_halted", halted, 0);
    check("rst_state", dbg_state, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    step();

    // ADC
    out_ready = 1'b1; iw = 16'h0A52; in_pc = 16'h0010; in_valid = 1'b1;
    #1 check("adc_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("adc_valid", out_valid, 1);
    check("adc_rd_sel", rd_sel, 2'b10);
    check("adc_alu_op", alu_op, 3'b010);
    check("adc_w_reg", w_reg, 1);
    check("adc_mem_ans", mem_ans, 1);
    check("adc_first_last", {out_first, out_last}, 2'b11);
    check("adc_ctl", ctl, C_ADC);
    check("adc_iw", out_iw, 16'h0A52);
    check("adc_pc", out_pc, 16'h0010);
    step();
    check("adc_drain", out_valid, 0);

    // decode table, back to back
    for (int i = 0; i < 18; i++) begin
      iw = vec_iw[i]; in_pc = 16'h0100 + 16'(i); in_valid = 1'b1;
      #1 check($sformatf("vec%0d_in_ready", i), in_ready, 1);
      step();
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      check($sformatf("vec%0d_ctl", i), ctl, vec_ctl[i]);
      check($sformatf("vec%0d_iw", i), out_iw, vec_iw[i]);
      check($sformatf("vec%0d_uop", i), uop, 8'b000_000_1_1);
    end
    in_valid = 1'b0;
    step();
    check("vec_drain", out_valid, 0);

    // LM list 1010_0100 with a follow-up ADD offered throughout
    exp_q.push_back({3'd2, 3'd0, 1'b1, 1'b0});
    exp_q.push_back({3'd5, 3'd1, 1'b0, 1'b0});
    exp_q.push_back({3'd7, 3'd2, 1'b0, 1'b1});
    iw = 16'h60A4; in_pc = 16'h0300; in_valid = 1'b1;
    #1 check("lm_in_ready0", in_ready, 1);
    step();
    iw = 16'h0A50; in_pc = 16'h0302;
    #1;
    check_uop_q("lm_uop0");
    check("lm_ctl", ctl, C_LM);
    check("lm_iw", out_iw, 16'h60A4);
    check("lm_stall1", in_ready, 0);
    check("lm_state_exp", dbg_state, 1);
    step();
    check_uop_q("lm_uop1");
    check("lm_stall2", in_ready, 0);
    step();
    check_uop_q("lm_uop2");
    check("lm_valid2", out_valid, 1);
    check("lm_ready_back", in_ready, 1);
    check("lm_state_idle", dbg_state, 0);
    step();
    in_valid = 1'b0;
    check("lm_follow_iw", out_iw, 16'h0A50);
    check("lm_follow_ctl", ctl, C_ADD);
    check("lm_follow_uop", uop, 8'b000_000_1_1);
    step();
    check("lm_drain", out_valid, 0);

    // SM list 0x81 with a 3-cycle downstream stall after the first micro-op
    out_ready = 1'b0; iw = 16'h7081; in_pc = 16'h0400; in_valid = 1'b1;
    #1 check("sm_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("sm_uop0", uop, {3'd0, 3'd0, 1'b1, 1'b0});
    check("sm_lmstart0", lmstart, 2'b10);
    check("sm_w_mem0", w_mem, 1);
    check("sm_ctl", ctl, C_SM);
    for (int j = 0; j < 3; j++) begin
      step();
      check($sformatf("sm_hold%0d_valid", j), out_valid, 1);
      check($sformatf("sm_hold%0d_uop", j), uop, {3'd0, 3'd0, 1'b1, 1'b0});
      check($sformatf("sm_hold%0d_in_ready", j), in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    check("sm_uop1", uop, {3'd7, 3'd1, 1'b0, 1'b1});
    check("sm_valid1", out_valid, 1);
    check("sm_lmstart1", lmstart, 2'b10);
    check("sm_w_mem1", w_mem, 1);
    check("sm_state_idle", dbg_state, 0);
    step();
    check("sm_drain", out_valid, 0);

    // flush during the 2nd micro-op of LM list 0000_1110
    iw = 16'h600E; in_pc = 16'h0500; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("fl_uop0", uop, {3'd1, 3'd0, 1'b1, 1'b0});
    step();
    check("fl_uop1", uop, {3'd2, 3'd1, 1'b0, 1'b0});
    flush = 1'b1; iw = 16'h1234; in_pc = 16'h0600; in_valid = 1'b1;
    #1 check("fl_in_ready_low", in_ready, 0);
    step();
    flush = 1'b0;
    #1;
    check("fl_valid_killed", out_valid, 0);
    check("fl_state_idle", dbg_state, 0);
    check("fl_in_ready_back", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("fl_next_valid", out_valid, 1);
    check("fl_next_iw", out_iw, 16'h1234);
    check("fl_next_pc", out_pc, 16'h0600);
    check("fl_next_uop", uop, 8'b000_000_1_1);
    step();
    check("fl_drain", out_valid, 0);

    // unconsumed HALT is killed by flush
    out_ready = 1'b0; iw = 16'hFFFF; in_pc = 16'h0700; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("hk_valid", out_valid, 1);
    check("hk_ctl", ctl, C_HALT);
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    check("hk_killed", out_valid, 0);
    check("hk_halted", halted, 0);
    check("hk_state", dbg_state, 0);
    check("hk_in_ready", in_ready, 1);

    // HALT consumed
    out_ready = 1'b1; iw = 16'hFFFF; in_pc = 16'h0800; in_valid = 1'b1;
    step();
    iw = 16'h0A50; in_pc = 16'h0802;
    check("halt_stop", stop, 1);
    check("halt_ctl", ctl, C_HALT);
`ifdef LMSM_DEC_HALT_STICKY_EN
    #1 check("halt_hold_in_ready", in_ready, 0);
    step();
    check("halt_halted", halted, 1);
    check("halt_in_ready", in_ready, 0);
    check("halt_valid", out_valid, 0);
    check("halt_state", dbg_state, 2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    check("halt_flush_halted", halted, 1);
    check("halt_flush_in_ready", in_ready, 0);
    check("halt_flush_valid", out_valid, 0);
    step();
    in_valid = 1'b0;
    check("halt_persist", halted, 1);
    check("halt_persist_valid", out_valid, 0);
    rst_n = 1'b0;
    #1;
    check("halt_rst_halted", halted, 0);
    check("halt_rst_state", dbg_state, 0);
    step();
    rst_n = 1'b1;
    step();
    check("halt_rst_in_ready", in_ready, 1);
`else
    #1 check("halt_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("halt_halted", halted, 0);
    check("halt_next_valid", out_valid, 1);
    check("halt_next_iw", out_iw, 16'h0A50);
    check("halt_next_stop", stop, 0);
    step();
    check("halt_drain", out_valid, 0);
`endif

    // reset asserted mid-expansion
    iw = 16'h60FF; in_pc = 16'h0900; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("mr_uop1", uop, {3'd1, 3'd1, 1'b0, 1'b0});
    check("mr_state", dbg_state, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_valid", out_valid, 0);
    check("mr_state_rst", dbg_state, 0);
    check("mr_ctl", ctl, 0);
    check("mr_iw", out_iw, 0);
    check("mr_uop", uop, 0);
    step();
    rst_n = 1'b1;
    step();
    check("mr_no_resume", out_valid, 0);
    check("mr_in_ready", in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
